serial_pattern_tx: RTL and testbench

Serial pattern transmitter: on a start request it drives a parameterised bit pattern (default 1011) MSB-first on a one-bit serial line. The pattern is repeated a programmable number of times, with a programmable run of zero gap bits between repetitions. It is the driving end of the serial input used by the Mealy/Moore sequence detectors, and serves as an on-chip stimulus source and loopback partner for them.

---
 rtl/serial_pattern_tx.sv | 165 ++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends PAT MSB-first a latched number of times,
// separated by a latched run of zero gap bits. All outputs are registered.
module serial_pattern_tx #(
   parameter int unsigned       PAT_W = 4,
   parameter logic [PAT_W-1:0]  PAT   = 4'b1011,
   parameter int unsigned       CNT_W = 8,
   parameter int unsigned       GAP_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sent_cnt
);

   localparam int unsigned      IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] idx_dec;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [GAP_W-1:0] gap_len_q, gap_len_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] sent_q, sent_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   assign idx_dec = idx_q - IDX_W'(1);

   // rem_q counts repetitions still owed, including the one on the line.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rem_d     = rem_q;
      gap_len_d = gap_len_q;
      gap_cnt_d = gap_cnt_q;
      sent_d    = sent_q;
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               sent_d = '0;
               if (count != '0) begin
                  state_d   = StSend;
                  idx_d     = IDX_TOP;
                  rem_d     = count;
                  gap_len_d = gap;
                  x_d       = PAT[PAT_W-1];
                  x_valid_d = 1'b1;
                  busy_d    = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         StSend: begin
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
            if (idx_q == '0) begin
               sent_d = sent_q + CNT_W'(1);
               rem_d  = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d   = StIdle;
                  x_valid_d = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else if (gap_len_q != '0) begin
                  state_d   = StGap;
                  gap_cnt_d = gap_len_q;
               end else begin
                  idx_d = IDX_TOP;
                  x_d   = PAT[PAT_W-1];
               end
            end else begin
               idx_d = idx_dec;
               x_d   = PAT[idx_dec];
            end
         end

         StGap: begin
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
            if (gap_cnt_q == GAP_W'(1)) begin
               state_d = StSend;
               idx_d   = IDX_TOP;
               x_d     = PAT[PAT_W-1];
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // A pattern whose last bit completes on the abort edge still counts.
      if (abort && (state_q != StIdle)) begin
         state_d   = StIdle;
         x_d       = 1'b0;
         x_valid_d = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         rem_q     <= '0;
         gap_len_q <= '0;
         gap_cnt_q <= '0;
         sent_q    <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rem_q     <= rem_d;
         gap_len_q <= gap_len_d;
         gap_cnt_q <= gap_cnt_d;
         sent_q    <= sent_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign x        = x_q;
   assign x_valid  = x_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign sent_cnt = sent_q;

`ifndef SYNTHESIS
   a_x_quiet : assert property (@(posedge clk) disable iff (!reset) !x_valid |-> !x);
   a_done_idle : assert property (@(posedge clk) disable iff (!reset) done |-> !busy);
   a_busy_valid : assert property (@(posedge clk) disable iff (!reset) busy == x_valid);
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomized self-checking bench for serial_pattern_tx against a bit-stream model
// built from pattern, repetition count and gap length.
module tb_serial_pattern_tx;

   localparam int         PAT_W = 4;
   localparam logic [3:0] PAT   = 4'b1011;
   localparam int         CNT_W = 8;
   localparam int         GAP_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] count = '0;
   logic [GAP_W-1:0] gap = '0;
   logic             abort = 1'b0;
   logic             x, x_valid, busy, done;
   logic [CNT_W-1:0] sent_cnt;

   int checks = 0;
   int errors = 0;
   bit exp_x[$];
   int exp_sent[$];

   serial_pattern_tx #(
      .PAT_W(PAT_W),
      .PAT  (PAT),
      .CNT_W(CNT_W),
      .GAP_W(GAP_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .count   (count),
      .gap     (gap),
      .abort   (abort),
      .x       (x),
      .x_valid (x_valid),
      .busy    (busy),
      .done    (done),
      .sent_cnt(sent_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected line contents per valid cycle, and sent_cnt shown during that cycle.
   function automatic void build(input int c, input int g);
      logic [PAT_W-1:0] p;
      p = PAT;
      exp_x.delete();
      exp_sent.delete();
      for (int r = 0; r < c; r++) begin
         for (int b = PAT_W - 1; b >= 0; b--) begin
            exp_x.push_back(p[b]);
            exp_sent.push_back(r);
         end
         if (r < c - 1) begin
            for (int k = 0; k < g; k++) begin
               exp_x.push_back(1'b0);
               exp_sent.push_back(r + 1);
            end
         end
      end
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if ({x, x_valid, busy, done} !== 4'b0000 || sent_cnt !== '0) begin
         errors++;
         $display("FAIL reset: got x/v/b/d=%b%b%b%b sent=%0d, want 0000 sent=0",
                  x, x_valid, busy, done, sent_cnt);
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({x, x_valid, busy, done} !== 4'b0000 || sent_cnt !== '0) begin
         errors++;
         $display("FAIL reset_release: got x/v/b/d=%b%b%b%b sent=%0d, want idle",
                  x, x_valid, busy, done, sent_cnt);
      end
   endtask

   task automatic test_transfers();
      int cs[6] = '{1, 3, 2, 1, 255, 2};
      int gs[6] = '{0, 2, 0, 15, 15, 1};
      for (int t = 0; t < 12; t++) begin
         int c, g, hits;
         logic [3:0] sh;
         if (t < 6) begin
            c = cs[t];
            g = gs[t];
         end else begin
            c = $urandom_range(1, 12);
            g = $urandom_range(0, 15);
         end
         build(c, g);
         hits = 0;
         sh = '0;
         start = 1'b1;
         count = CNT_W'(c);
         gap = GAP_W'(g);
         tick();
         start = 1'b0;
         count = CNT_W'($urandom);
         gap = GAP_W'($urandom);
         for (int i = 0; i < exp_x.size(); i++) begin
            checks++;
            if ({x_valid, busy, done, x} !== {3'b110, exp_x[i]} ||
                sent_cnt !== CNT_W'(exp_sent[i])) begin
               errors++;
               $display("FAIL xfer c=%0d g=%0d cyc=%0d: got v/b/d/x=%b%b%b%b sent=%0d, want 110%b sent=%0d",
                        c, g, i, x_valid, busy, done, x, sent_cnt, exp_x[i], exp_sent[i]);
            end
            if (x_valid) begin
               sh = {sh[2:0], x};
               if (sh == 4'b1011) hits++;
            end
            tick();
         end
         checks++;
         if ({x_valid, busy, done, x} !== 4'b0010 || sent_cnt !== CNT_W'(c)) begin
            errors++;
            $display("FAIL xfer_done c=%0d g=%0d: got v/b/d/x=%b%b%b%b sent=%0d, want 0010 sent=%0d",
                     c, g, x_valid, busy, done, x, sent_cnt, c);
         end
         // 1011 cannot straddle a repetition boundary, so a detector sees exactly c hits.
         checks++;
         if (hits != c) begin
            errors++;
            $display("FAIL detect c=%0d g=%0d: got %0d hits, want %0d", c, g, hits, c);
         end
         tick();
         checks++;
         if ({done, busy, x_valid} !== 3'b000) begin
            errors++;
            $display("FAIL done_pulse c=%0d: got d/b/v=%b%b%b, want 000", c, done, busy, x_valid);
         end
      end
   endtask

   task automatic test_busy_ignore();
      build(2, 0);
      start = 1'b1;
      count = 8'd2;
      gap = 4'd0;
      tick();
      for (int i = 0; i < exp_x.size(); i++) begin
         start = (i < exp_x.size() - 1) ? ((i % 2) == 0) : 1'b0;
         count = 8'd5;
         gap = 4'd3;
         checks++;
         if ({x_valid, busy, done, x} !== {3'b110, exp_x[i]} ||
             sent_cnt !== CNT_W'(exp_sent[i])) begin
            errors++;
            $display("FAIL busy_ignore cyc=%0d: got v/b/d/x=%b%b%b%b sent=%0d, want 110%b sent=%0d",
                     i, x_valid, busy, done, x, sent_cnt, exp_x[i], exp_sent[i]);
         end
         tick();
      end
      start = 1'b0;
      checks++;
      if ({x_valid, busy, done} !== 3'b001 || sent_cnt !== 8'd2) begin
         errors++;
         $display("FAIL busy_ignore_done: got v/b/d=%b%b%b sent=%0d, want 001 sent=2",
                  x_valid, busy, done, sent_cnt);
      end
      tick();
      checks++;
      if ({x_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL busy_ignore_queue: got v/b/d=%b%b%b, want 000", x_valid, busy, done);
      end
   endtask

   task automatic test_abort();
      build(5, 1);
      start = 1'b1;
      count = 8'd5;
      gap = 4'd1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         abort = (i == 6);
         checks++;
         if ({x_valid, x} !== {1'b1, exp_x[i]} || sent_cnt !== CNT_W'(exp_sent[i])) begin
            errors++;
            $display("FAIL abort_run cyc=%0d: got v/x=%b%b sent=%0d, want 1%b sent=%0d",
                     i, x_valid, x, sent_cnt, exp_x[i], exp_sent[i]);
         end
         tick();
      end
      abort = 1'b0;
      checks++;
      if ({x, x_valid, busy, done} !== 4'b0000 || sent_cnt !== 8'd1) begin
         errors++;
         $display("FAIL abort_stop: got x/v/b/d=%b%b%b%b sent=%0d, want 0000 sent=1",
                  x, x_valid, busy, done, sent_cnt);
      end
      build(1, 0);
      start = 1'b1;
      count = 8'd1;
      gap = 4'd0;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_x.size(); i++) begin
         checks++;
         if ({x_valid, busy, done, x} !== {3'b110, exp_x[i]} || sent_cnt !== 8'd0) begin
            errors++;
            $display("FAIL abort_restart cyc=%0d: got v/b/d/x=%b%b%b%b sent=%0d, want 110%b sent=0",
                     i, x_valid, busy, done, x, sent_cnt, exp_x[i]);
         end
         tick();
      end
      checks++;
      if ({x_valid, busy, done} !== 3'b001 || sent_cnt !== 8'd1) begin
         errors++;
         $display("FAIL abort_restart_done: got v/b/d=%b%b%b sent=%0d, want 001 sent=1",
                  x_valid, busy, done, sent_cnt);
      end
      // Abort together with start in idle must not start anything.
      abort = 1'b1;
      start = 1'b1;
      count = 8'd3;
      tick();
      abort = 1'b0;
      start = 1'b0;
      checks++;
      if ({x_valid, busy, done} !== 3'b000 || sent_cnt !== 8'd1) begin
         errors++;
         $display("FAIL abort_idle: got v/b/d=%b%b%b sent=%0d, want 000 sent=1",
                  x_valid, busy, done, sent_cnt);
      end
   endtask

   task automatic test_zero_count();
      start = 1'b1;
      count = 8'd0;
      gap = 4'd5;
      tick();
      checks++;
      if ({x_valid, busy, done} !== 3'b001 || sent_cnt !== 8'd0) begin
         errors++;
         $display("FAIL zero_count: got v/b/d=%b%b%b sent=%0d, want 001 sent=0",
                  x_valid, busy, done, sent_cnt);
      end
      build(2, 1);
      count = 8'd2;
      gap = 4'd1;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_x.size(); i++) begin
         checks++;
         if ({x_valid, busy, done, x} !== {3'b110, exp_x[i]} ||
             sent_cnt !== CNT_W'(exp_sent[i])) begin
            errors++;
            $display("FAIL zero_then_start cyc=%0d: got v/b/d/x=%b%b%b%b sent=%0d, want 110%b sent=%0d",
                     i, x_valid, busy, done, x, sent_cnt, exp_x[i], exp_sent[i]);
         end
         tick();
      end
      checks++;
      if ({x_valid, busy, done} !== 3'b001 || sent_cnt !== 8'd2) begin
         errors++;
         $display("FAIL zero_then_start_done: got v/b/d=%b%b%b sent=%0d, want 001 sent=2",
                  x_valid, busy, done, sent_cnt);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      build(1, 0);
      start = 1'b1;
      count = 8'd1;
      gap = 4'd0;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_x.size(); i++) tick();
      checks++;
      if ({x_valid, busy, done} !== 3'b001) begin
         errors++;
         $display("FAIL b2b_first_done: got v/b/d=%b%b%b, want 001", x_valid, busy, done);
      end
      build(2, 3);
      start = 1'b1;
      count = 8'd2;
      gap = 4'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < exp_x.size(); i++) begin
         checks++;
         if ({x_valid, busy, done, x} !== {3'b110, exp_x[i]} ||
             sent_cnt !== CNT_W'(exp_sent[i])) begin
            errors++;
            $display("FAIL b2b cyc=%0d: got v/b/d/x=%b%b%b%b sent=%0d, want 110%b sent=%0d",
                     i, x_valid, busy, done, x, sent_cnt, exp_x[i], exp_sent[i]);
         end
         tick();
      end
      checks++;
      if ({x_valid, busy, done} !== 3'b001 || sent_cnt !== 8'd2) begin
         errors++;
         $display("FAIL b2b_done: got v/b/d=%b%b%b sent=%0d, want 001 sent=2",
                  x_valid, busy, done, sent_cnt);
      end
      tick();
   endtask

   task automatic test_async_reset();
      start = 1'b1;
      count = 8'd4;
      gap = 4'd2;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({x, x_valid, busy, done} !== 4'b0000 || sent_cnt !== '0) begin
         errors++;
         $display("FAIL async_reset: got x/v/b/d=%b%b%b%b sent=%0d, want 0000 sent=0",
                  x, x_valid, busy, done, sent_cnt);
      end
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({x, x_valid, busy, done} !== 4'b0000 || sent_cnt !== '0) begin
            errors++;
            $display("FAIL post_reset_idle cyc=%0d: got x/v/b/d=%b%b%b%b sent=%0d, want idle",
                     i, x, x_valid, busy, done, sent_cnt);
         end
      end
      start = 1'b1;
      count = 8'd1;
      gap = 4'd0;
      tick();
      start = 1'b0;
      checks++;
      if ({x_valid, busy, x} !== 3'b111) begin
         errors++;
         $display("FAIL post_reset_start: got v/b/x=%b%b%b, want 111", x_valid, busy, x);
      end
      for (int i = 0; i < 5; i++) tick();
   endtask

   initial begin
      test_reset();
      test_transfers();
      test_busy_ignore();
      test_abort();
      test_zero_count();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
